// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed streaming FIFO controller.
package ram_fifo_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] ptr_t;
   typedef logic [ADDR_W:0]   lvl_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready word stream; master drives valid/data, slave drives ready.
interface ram_fifo_ctrl_if;
   import ram_fifo_pkg::*;

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ram_fifo_obuf.sv
// Small register FIFO that absorbs RAM read data and presents the head word.
module ram_fifo_obuf
   import ram_fifo_pkg::*;
#(
   parameter int OBUF_DEPTH = 4,
   localparam int IW = $clog2(OBUF_DEPTH),
   localparam int CW = IW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              valid,
   output logic [CW-1:0]     cnt
);
   logic [DATA_W-1:0] mem [OBUF_DEPTH];
   logic [IW-1:0]     wr_idx;
   logic [IW-1:0]     rd_idx;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         if (wr_en) wr_idx <= wr_idx + IW'(1);
         if (rd_en) begin
            rd_idx <= rd_idx + IW'(1);
            last_q <= mem[rd_idx];
         end
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_idx] <= wr_data;
   end

   // When empty, keep showing the most recently popped word.
   assign valid   = (cnt_q != '0);
   assign rd_data = valid ? mem[rd_idx] : last_q;
   assign cnt     = cnt_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer controller over a 1-cycle registered dual-port RAM; port A writes, port B reads.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int OBUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   ram_fifo_ctrl_if.slave    s,
   ram_fifo_ctrl_if.master   m,
   output lvl_t              level,
   output logic              full,
   output ptr_t              ram_addr_a,
   output logic [DATA_W-1:0] ram_din_a,
   output logic              ram_we_a,
   output ptr_t              ram_addr_b,
   output logic [DATA_W-1:0] ram_din_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_dout_b
);
   localparam int CW = $clog2(OBUF_DEPTH) + 1;

   logic          flush;
   logic          push;
   logic          pop;
   logic          rd_issue;
   logic          capture;
   ptr_t          wr_ptr;
   ptr_t          rd_ptr;
   lvl_t          level_q;
   lvl_t          ram_cnt;
   logic          inflight;
   logic [CW-1:0] obuf_cnt;
   logic [CW:0]   occ;
   logic          obuf_valid;

   assign flush = rst || clr;
   assign full  = (level_q == lvl_t'(DEPTH));

   assign s.ready = !full;
   assign push    = s.valid && !full && !flush;
   assign pop     = obuf_valid && m.ready && !flush;

   // Reserve an obuf slot for the read in flight so capture never overflows.
   assign occ      = {1'b0, obuf_cnt} + (CW+1)'(inflight);
   assign rd_issue = (ram_cnt != '0) && (occ < (CW+1)'(OBUF_DEPTH)) && !flush;
   assign capture  = inflight && !flush;

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         level_q  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + ptr_t'(1);
         if (rd_issue) rd_ptr <= rd_ptr + ptr_t'(1);
         inflight <= rd_issue;
         ram_cnt  <= ram_cnt + lvl_t'(push) - lvl_t'(rd_issue);
         level_q  <= level_q + lvl_t'(push) - lvl_t'(pop);
      end
   end

   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr;
   assign ram_din_a  = s.data;
   assign ram_addr_b = rd_ptr;
   assign ram_din_b  = '0;
   assign ram_we_b   = 1'b0;
   assign level      = level_q;

   // Stage boundary: RAM read data registered one cycle after issue lands here.
   ram_fifo_obuf #(.OBUF_DEPTH(OBUF_DEPTH)) u_obuf (
      .clk     (clk),
      .rst     (flush),
      .wr_en   (capture),
      .wr_data (ram_dout_b),
      .rd_en   (pop),
      .rd_data (m.data),
      .valid   (obuf_valid),
      .cnt     (obuf_cnt)
   );

   assign m.valid = obuf_valid;
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Streaming FIFO controller that sequences the team's 32-bit x 16K dual-port block RAM as a circular buffer.
- Producer writes through RAM port A. The controller reads through RAM port B (port B write is tied off).
- Valid/ready handshakes on both sides.
- A small output buffer hides the 1-cycle registered RAM read latency and sustains 1 word/cycle in and out.

Parameters:
- DATA_W, 32, word width; must match the RAM.
- ADDR_W, 14, RAM address width; DEPTH = 2**ADDR_W = 16384 words.
- OBUF_DEPTH, 4, output buffer entries; power of two, at least 4.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on controller state.
- s_valid  in  1  producer word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  DATA_W  producer word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  head-of-FIFO word.
- level  out  ADDR_W+1  words accepted and not yet popped.
- full  out  1  level == DEPTH.
- ram_addr_a  out  ADDR_W  RAM port A address.
- ram_din_a  out  DATA_W  RAM port A data.
- ram_we_a  out  1  RAM port A write enable.
- ram_addr_b  out  ADDR_W  RAM port B address.
- ram_din_b  out  DATA_W  constant 0.
- ram_we_b  out  1  constant 0.
- ram_dout_b  in  DATA_W  RAM port B registered read data.

Behaviour:
- Reset (rst or clr high at posedge):
  - wr_ptr, rd_ptr, level, ram_cnt, obuf count and pointers, and the inflight bit all go to 0.
  - Outputs: s_ready=1, m_valid=0, full=0, level=0, ram_we_a=0, m_data=0.
  - RAM contents are not cleared.
  - A read in flight at reset is discarded: its inflight bit is cleared, so its data is never captured.
  - rst has priority over all other events that cycle.
- Push:
  - push = s_valid && s_ready; s_ready = !full (registered-derived, no combinational path from s_valid).
  - On push: ram_we_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data (combinational pass-through), wr_ptr+1.
  - wr_ptr wraps modulo DEPTH at 16383 -> 0.
- Read issue:
  - rd_issue = (ram_cnt != 0) && (obuf_cnt + inflight < OBUF_DEPTH).
  - On rd_issue: ram_addr_b=rd_ptr, rd_ptr+1 (wraps), inflight <= 1.
  - ram_cnt counts words written but not yet issued: +push -rd_issue, both allowed in the same cycle.
  - A read only targets an address written in an earlier cycle, so there is no same-cycle read/write collision on an address.
- Capture:
  - The cycle after rd_issue, ram_dout_b is valid and is written into obuf at its tail.
  - inflight clears unless a new issue occurs that cycle.
- Pop:
  - pop = m_valid && m_ready; m_valid = (obuf_cnt != 0); m_data = obuf head.
  - Capture and pop in the same cycle leave obuf_cnt unchanged.
- level: +push -pop; unchanged on simultaneous push and pop. full is asserted only at level == 16384.
- Latency: push accepted in cycle N -> m_valid high in cycle N+3 (N+1 read issue, N+2 capture, N+3 present).
- Throughput: sustained 1 push and 1 pop per cycle with no bubbles once primed.
- Full: s_ready=0; a push attempt is ignored, with no write and no pointer change.
- Empty: m_valid=0; m_data holds its last value; m_ready is ignored.
- Invariant: level == ram_cnt + inflight + obuf_cnt.

Decomposition:
- Package ram_fifo_pkg holds:
  - DATA_W, ADDR_W, DEPTH constants.
  - The pointer type (ADDR_W bits) and the level type (ADDR_W+1 bits).
- One sub-module, ram_fifo_obuf: an OBUF_DEPTH-entry register FIFO holding the capture/pop logic and obuf_cnt.
- The RAM itself is instantiated beside the controller by the parent, not inside it.

Test Plan:
- Reset then push 0xA5A5_0001 in cycle 0 with m_ready=1 -> m_valid=1 and m_data=0xA5A5_0001 in cycle 3; level 1 in cycles 1..3, then 0.
- Stream 1000 incrementing words with s_valid and m_ready held high -> all 1000 words out in order with no gaps after the first; level stays <= 4.
- Hold m_ready=0 and push 16384 words -> full=1 and s_ready=0 at level 16384; a 16385th push is ignored; then drain -> values 0..16383 in order.
- Wrap: push and pop 20000 words, random m_ready at 50% -> in-order data across wr_ptr/rd_ptr wrap; the invariant holds every cycle.
- At level 16384, one push attempt and one pop in the same cycle -> the push is rejected, level 16383; next cycle s_ready=1.
- Assert rst with 10 words buffered and a read in flight -> next cycle m_valid=0, level=0, s_ready=1; the stale word never appears; a new push of 0x1234 appears 3 cycles later.
